mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data path width.
REQ-002 The block SHALL have parameter ADDRSIZE, default 12, data memory address width.
REQ-003 The block SHALL have parameter BURST_MAX, default 4, maximum consecutive grant cycles per owner while the other requester waits.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-low reset; sampled on posedge clk.
REQ-006 m0_req / m1_req  in  1  requester 0 (CPU) / requester 1 (loader/debug) wants the memory port.
REQ-007 m0_we / m1_we  in  1  1 = write, 0 = read.
REQ-008 m0_addr / m1_addr  in  ADDRSIZE  access address.
REQ-009 m0_wdata / m1_wdata  in  WIDTH  write data.
REQ-010 m0_gnt / m1_gnt  out  1  registered grant; the requester owns the port this cycle.
REQ-011 m0_rdata / m1_rdata  out  WIDTH  registered read data.
REQ-012 m0_rvalid / m1_rvalid  out  1  one-cycle pulse; rdata is valid.
REQ-013 mem_addr  out  ADDRSIZE  data memory address.
REQ-014 mem_wdata  out  WIDTH  data memory write data.
REQ-015 mem_we  out  1  data memory write strobe.
REQ-016 mem_rdata  in  WIDTH  data memory read data, combinational from mem_addr.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, OWN0 and OWN1; m0_gnt = (state==OWN0), m1_gnt = (state==OWN1).
REQ-018 An access SHALL occur in every cycle where mX_gnt=1 and mX_req=1; no access occurs in any other cycle.
REQ-019 During an access, mem_addr and mem_wdata SHALL equal the owner's addr and wdata, and mem_we SHALL equal the owner's we; otherwise mem_addr=0, mem_wdata=0 and mem_we=0.
REQ-020 For a read access, mem_rdata SHALL be captured into the owner's rdata at the closing edge, with that owner's rvalid=1 for exactly the next cycle; the other rdata is unchanged.
REQ-021 A write access SHALL not pulse rvalid.
REQ-022 From IDLE, a single requester SHALL move the FSM to its OWN state; when both request, the FSM SHALL move to the requester that is not last_owner (round-robin).
REQ-023 Grant latency SHALL be one cycle: req first high in cycle N gives gnt high in cycle N+1 when the port is idle.
REQ-024 In OWNx with mx_req=1: stay (burst_cnt+1) if the other requester is idle or burst_cnt < BURST_MAX-1; otherwise move to the other OWN state with burst_cnt=0.
REQ-025 In OWNx with mx_req=0: move to the other OWN state if it requests, else to IDLE; burst_cnt=0.
REQ-026 burst_cnt SHALL be clog2(BURST_MAX)+1 bits wide, SHALL saturate at BURST_MAX-1 while the other requester is idle, and SHALL clear on every state change.
REQ-027 last_owner SHALL update to x on every entry to OWNx.
REQ-028 A requester SHALL keep addr, we and wdata stable while req=1 and gnt=0; the arbiter does not buffer requests.

Reset
REQ-029 While rst=0 at posedge clk: state=IDLE, last_owner=1 (m0 wins the first tie), burst_cnt=0, both gnt=0, both rvalid=0, both rdata=0.
REQ-030 mem_we SHALL be 0 combinationally whenever rst=0, including a reset applied mid-burst; no memory write occurs in a reset cycle.
REQ-031 A read access in a reset cycle SHALL produce no rvalid.

Verification
REQ-032 Reset: hold rst=0 for 2 cycles with both req=1 -> both gnt=0, both rvalid=0, mem_we=0, mem_addr=0 throughout.
REQ-033 Single write: m0_req=1, we=1, addr=5, wdata=0x1234 in cycle 0 -> cycle 1: m0_gnt=1, mem_we=1, mem_addr=5, mem_wdata=0x1234; m1_gnt=0.
REQ-034 Single read: memory[7]=99; m1 reads addr 7 -> m1_gnt=1 in cycle 1, m1_rvalid=1 and m1_rdata=99 in cycle 2, m0_rvalid=0.
REQ-035 Contention: both req held high from release of reset -> grant sequence m0 x4, m1 x4, m0 x4; mem_we is never 1 for a non-owner.
REQ-036 Mid-burst reset: m0 writing in OWN0 with burst_cnt=2, then rst=0 for one cycle -> mem_we=0 that cycle; after release with both requesting, m0 is granted first.
REQ-037 Drop-out: m0 owns and drops req while m1 is idle -> FSM goes to IDLE next cycle; m1_req then rises -> m1_gnt=1 one cycle later.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Grants are registered FSM states; bursts are capped only while the other side waits.
module mem_arbiter #(
    parameter int WIDTH     = 32,
    parameter int ADDRSIZE  = 12,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDRSIZE-1:0] m0_addr,
    input  logic [WIDTH-1:0]    m0_wdata,
    output logic                m0_gnt,
    output logic [WIDTH-1:0]    m0_rdata,
    output logic                m0_rvalid,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDRSIZE-1:0] m1_addr,
    input  logic [WIDTH-1:0]    m1_wdata,
    output logic                m1_gnt,
    output logic [WIDTH-1:0]    m1_rdata,
    output logic                m1_rvalid,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    output logic                mem_we,
    input  logic [WIDTH-1:0]    mem_rdata
);

    localparam int CW = $clog2(BURST_MAX) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          r_state, w_next_state;
    logic            r_last_owner, w_next_last;
    logic [CW-1:0]   r_burst_cnt, w_next_cnt;
    logic [WIDTH-1:0] r_m0_rdata, r_m1_rdata;
    logic            r_m0_rvalid, r_m1_rvalid;
    logic            w_acc0, w_acc1;
    logic            w_rd0, w_rd1;
    logic            w_cnt_room;

    assign w_acc0     = (r_state == OWN0) && m0_req;
    assign w_acc1     = (r_state == OWN1) && m1_req;
    assign w_rd0      = w_acc0 && !m0_we;
    assign w_rd1      = w_acc1 && !m1_we;
    assign w_cnt_room = (r_burst_cnt < CNT_MAX);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = '0;
        w_next_last  = r_last_owner;
        case (r_state)
            IDLE: begin
                if (m0_req && m1_req)
                    w_next_state = r_last_owner ? OWN0 : OWN1;
                else if (m0_req)
                    w_next_state = OWN0;
                else if (m1_req)
                    w_next_state = OWN1;
            end
            OWN0: begin
                if (m0_req) begin
                    // keep the port while uncontested, counter pinned at its cap
                    if (!m1_req || w_cnt_room) begin
                        w_next_state = OWN0;
                        w_next_cnt   = w_cnt_room ? r_burst_cnt + 1'b1 : r_burst_cnt;
                    end else begin
                        w_next_state = OWN1;
                    end
                end else begin
                    w_next_state = m1_req ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (m1_req) begin
                    if (!m0_req || w_cnt_room) begin
                        w_next_state = OWN1;
                        w_next_cnt   = w_cnt_room ? r_burst_cnt + 1'b1 : r_burst_cnt;
                    end else begin
                        w_next_state = OWN0;
                    end
                end else begin
                    w_next_state = m0_req ? OWN0 : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (w_next_state == OWN0)
            w_next_last = 1'b0;
        else if (w_next_state == OWN1)
            w_next_last = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_owner <= 1'b1;
            r_burst_cnt  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_last_owner <= w_next_last;
            r_burst_cnt  <= w_next_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_m0_rvalid <= w_rd0;
            r_m1_rvalid <= w_rd1;
            if (w_rd0)
                r_m0_rdata <= mem_rdata;
            if (w_rd1)
                r_m1_rdata <= mem_rdata;
        end
    end

    // write strobe is gated by reset directly so a mid-burst reset never writes
    assign mem_we    = rst && ((w_acc0 && m0_we) || (w_acc1 && m1_we));
    assign mem_addr  = w_acc0 ? m0_addr  : (w_acc1 ? m1_addr  : '0);
    assign mem_wdata = w_acc0 ? m0_wdata : (w_acc1 ? m1_wdata : '0);

    assign m0_gnt    = (r_state == OWN0);
    assign m1_gnt    = (r_state == OWN1);
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected reads/writes queued at issue time,
// a negedge monitor pops them as the DUT presents rvalid or mem_we.
module tb_mem_arbiter;
    localparam int W = 32;
    localparam int A = 12;

    logic         clk, rst;
    logic         m0_req, m0_we, m1_req, m1_we;
    logic [A-1:0] m0_addr, m1_addr, mem_addr;
    logic [W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic         m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;

    logic [W-1:0] mem [0:4095];
    logic [W-1:0] q_rd0[$];
    logic [W-1:0] q_rd1[$];
    logic [A+W-1:0] q_wr[$];
    int total = 0;
    int bad   = 0;

    localparam logic [W-1:0] DA = 32'hAAAA0010;
    localparam logic [W-1:0] DB = 32'hBBBB0011;

    mem_arbiter #(.WIDTH(W), .ADDRSIZE(A), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [A+W-1:0] ew;
        logic [W-1:0]   er;
        if (m0_rvalid) begin
            if (q_rd0.size() == 0) begin
                total++; bad++;
                $display("FAIL rd0_unexpected: got %0h expected none", m0_rdata);
            end else begin
                er = q_rd0.pop_front();
                chk("rd0_data", 64'(m0_rdata), 64'(er));
            end
        end
        if (m1_rvalid) begin
            if (q_rd1.size() == 0) begin
                total++; bad++;
                $display("FAIL rd1_unexpected: got %0h expected none", m1_rdata);
            end else begin
                er = q_rd1.pop_front();
                chk("rd1_data", 64'(m1_rdata), 64'(er));
            end
        end
        if (mem_we) begin
            chk("we_owner", 64'((m0_gnt && m0_req && m0_we) || (m1_gnt && m1_req && m1_we)), 64'd1);
            if (q_wr.size() == 0) begin
                total++; bad++;
                $display("FAIL wr_unexpected: got addr %0h data %0h expected none", mem_addr, mem_wdata);
            end else begin
                ew = q_wr.pop_front();
                chk("wr_addr_data", 64'({mem_addr, mem_wdata}), 64'(ew));
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[7]  = 32'd99;
        mem[10] = DA;
        mem[11] = DB;
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'd10; m0_wdata = '0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'd11; m1_wdata = '0;

        // reset with both requesting
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
            chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
            chk("rst_we_addr", {mem_we, mem_addr}, 0);
        end
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);

        // contention from reset release: m0 x4, m1 x4, m0 x4
        cyc(); rst = 1'b1;
        for (int i = 0; i < 8; i++) q_rd0.push_back(DA);
        for (int i = 0; i < 4; i++) q_rd1.push_back(DB);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("cont_gnt%0d", i), {m0_gnt, m1_gnt},
                (i >= 4 && i < 8) ? 64'b01 : 64'b10);
        end
        cyc(); m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) cyc();

        // single write by m0
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'd5; m0_wdata = 32'h1234;
        q_wr.push_back({12'd5, 32'h1234});
        @(posedge clk); @(negedge clk);
        chk("wr_gnt", {m0_gnt, m1_gnt}, 64'b10);
        chk("wr_bus", {mem_we, mem_addr, mem_wdata}, {1'b1, 12'd5, 32'h1234});
        cyc(); m0_req = 1'b0;
        @(negedge clk);
        chk("wr_tail_we", mem_we, 0);
        repeat (2) cyc();

        // single read by m1 of addr 7
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'd7;
        q_rd1.push_back(32'd99);
        @(posedge clk); @(negedge clk);
        chk("rd1_gnt", {m0_gnt, m1_gnt}, 64'b01);
        cyc(); m1_req = 1'b0;
        @(negedge clk);
        chk("rd1_pulse", {m0_rvalid, m1_rvalid}, 64'b01);
        cyc();
        @(negedge clk);
        chk("rd1_one_cycle", m1_rvalid, 0);
        repeat (2) cyc();

        // m0 reads back the earlier write
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'd5;
        q_rd0.push_back(32'h1234);
        cyc(); cyc(); m0_req = 1'b0;
        repeat (3) cyc();

        // uncontested burst past BURST_MAX, then m1 arrives
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'd40; m0_wdata = 32'd7;
        for (int i = 0; i < 7; i++) q_wr.push_back({12'd40, 32'd7});
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("sat_gnt%0d", i), m0_gnt, 1);
        end
        cyc(); m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'd11;
        q_rd1.push_back(DB);
        @(negedge clk);
        chk("sat_hold", {m0_gnt, m1_gnt}, 64'b10);
        cyc(); m0_req = 1'b0;
        @(negedge clk);
        chk("sat_switch", {m0_gnt, m1_gnt}, 64'b01);
        cyc(); m1_req = 1'b0;
        repeat (3) cyc();

        // mid-burst reset
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'd20; m0_wdata = 32'hBEEF;
        for (int i = 0; i < 3; i++) q_wr.push_back({12'd20, 32'hBEEF});
        cyc(); cyc(); cyc(); rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", mem_we, 0);
        cyc(); rst = 1'b1; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'd11;
        @(negedge clk);
        chk("post_rst_idle", {m0_gnt, m1_gnt}, 0);
        @(posedge clk); @(negedge clk);
        chk("post_rst_m0_first", {m0_gnt, m1_gnt}, 64'b10);
        cyc(); m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) cyc();

        // drop-out to IDLE, then m1 request
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'd10;
        q_rd0.push_back(DA);
        @(posedge clk); @(negedge clk);
        chk("drop_gnt", m0_gnt, 1);
        cyc(); m0_req = 1'b0;
        cyc();
        @(negedge clk);
        chk("drop_idle", {m0_gnt, m1_gnt}, 0);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'd30; m1_wdata = 32'h55;
        q_wr.push_back({12'd30, 32'h55});
        @(posedge clk); @(negedge clk);
        chk("drop_m1_gnt", {m0_gnt, m1_gnt}, 64'b01);
        cyc(); m1_req = 1'b0;
        repeat (4) cyc();

        chk("mem_30", mem[30], 32'h55);
        chk("q_rd0_empty", q_rd0.size(), 0);
        chk("q_rd1_empty", q_rd1.size(), 0);
        chk("q_wr_empty", q_wr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
